// File: rtl/game_ctrl.sv
// Two-player light-cycle game controller: clears the 64x48 tile map, places both players,
// then advances both heads one tile per tick, checking the map for collisions first.
//
// state  | meaning
// IDLE   | waiting for start_btn, mode=START
// CLEAR  | raster-writes FRAME border / EMPTY interior, one tile per cycle
// PLACE1 | writes PLAYER1 at its start tile
// PLACE2 | writes PLAYER2 at its start tile
// RUN    | game running, waiting for tick
// RD1    | reading the tile in front of player 1
// RD2    | reading the tile in front of player 2, capturing tile 1
// CHK    | capturing tile 2 and deciding crash / move
// WR1    | writing PLAYER1 at its new head
// WR2    | writing PLAYER2 at its new head
// WIN    | game over with a winner, waiting for start_btn
module game_ctrl #(
    parameter int P1_START_X = 16,
    parameter int P1_START_Y = 24,
    parameter int P2_START_X = 47,
    parameter int P2_START_Y = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_btn,
    input  logic [2:0] dir1,
    input  logic [2:0] dir2,
    output logic [5:0] map_x,
    output logic [5:0] map_y,
    output logic       map_we,
    output logic [1:0] map_wdata,
    input  logic [1:0] map_rdata,
    output logic [1:0] mode,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_PLACE1, S_PLACE2, S_RUN,
        S_RD1, S_RD2, S_CHK, S_WR1, S_WR2, S_WIN
    } state_t;

    localparam logic [2:0] D_WAIT  = 3'd0;
    localparam logic [2:0] D_RIGHT = 3'd1;
    localparam logic [2:0] D_LEFT  = 3'd2;
    localparam logic [2:0] D_UP    = 3'd3;
    localparam logic [2:0] D_DOWN  = 3'd4;

    localparam logic [1:0] T_EMPTY   = 2'd0;
    localparam logic [1:0] T_PLAYER1 = 2'd1;
    localparam logic [1:0] T_PLAYER2 = 2'd2;
    localparam logic [1:0] T_FRAME   = 2'd3;

    localparam logic [1:0] M_START   = 2'd0;
    localparam logic [1:0] M_GAME    = 2'd1;
    localparam logic [1:0] M_P1_WIN  = 2'd2;
    localparam logic [1:0] M_P2_WIN  = 2'd3;

    // Positions are packed {y, x} so they drop straight onto the map address port.
    localparam logic [11:0] P1_POS = {6'(P1_START_Y), 6'(P1_START_X)};
    localparam logic [11:0] P2_POS = {6'(P2_START_Y), 6'(P2_START_X)};

    function automatic logic [2:0] steer(input logic [2:0] req, input logic [2:0] cur);
        logic [2:0] opp;
        case (cur)
            D_RIGHT: opp = D_LEFT;
            D_LEFT:  opp = D_RIGHT;
            D_UP:    opp = D_DOWN;
            D_DOWN:  opp = D_UP;
            default: opp = D_WAIT;
        endcase
        if (req == D_WAIT || req == opp || req > D_DOWN)
            steer = cur;
        else
            steer = req;
    endfunction

    function automatic logic [11:0] step(input logic [11:0] pos, input logic [2:0] hd);
        logic [5:0] x;
        logic [5:0] y;
        {y, x} = pos;
        case (hd)
            D_RIGHT: x = x + 6'd1;
            D_LEFT:  x = x - 6'd1;
            D_UP:    y = y - 6'd1;
            D_DOWN:  y = y + 6'd1;
            default: ;
        endcase
        step = {y, x};
    endfunction

    function automatic logic [1:0] clear_tile(input logic [5:0] x, input logic [5:0] y);
        clear_tile = (x == 6'd0 || x == 6'd63 || y == 6'd0 || y == 6'd47) ? T_FRAME : T_EMPTY;
    endfunction

    state_t      state;
    logic [11:0] head1, head2;
    logic [2:0]  heading1, heading2;
    logic [1:0]  tile1;

    logic [2:0]  h1_req, h2_req;
    logic [11:0] n1_req, next1, next2;
    logic [5:0]  clr_x, clr_y;
    logic        crash1, crash2;

    always_comb begin
        h1_req = steer(dir1, heading1);
        h2_req = steer(dir2, heading2);
        n1_req = step(head1, h1_req);
        next1  = step(head1, heading1);
        next2  = step(head2, heading2);
        clr_x  = (map_x == 6'd63) ? 6'd0 : map_x + 6'd1;
        clr_y  = (map_x == 6'd63) ? map_y + 6'd1 : map_y;
        // tile2 is consumed straight off the read port in CHK
        crash1 = (tile1 != T_EMPTY) || (next1 == next2);
        crash2 = (map_rdata != T_EMPTY) || (next1 == next2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mode      <= M_START;
            busy      <= 1'b0;
            map_we    <= 1'b0;
            map_x     <= 6'd0;
            map_y     <= 6'd0;
            map_wdata <= T_EMPTY;
            heading1  <= D_WAIT;
            heading2  <= D_WAIT;
            head1     <= 12'd0;
            head2     <= 12'd0;
            tile1     <= T_EMPTY;
        end else begin
            case (state)
                S_IDLE, S_WIN: begin
                    if (start_btn) begin
                        state     <= S_CLEAR;
                        mode      <= M_START;
                        busy      <= 1'b1;
                        map_we    <= 1'b1;
                        map_x     <= 6'd0;
                        map_y     <= 6'd0;
                        map_wdata <= T_FRAME;
                    end
                end
                S_CLEAR: begin
                    if (map_x == 6'd63 && map_y == 6'd47) begin
                        state          <= S_PLACE1;
                        {map_y, map_x} <= P1_POS;
                        map_wdata      <= T_PLAYER1;
                    end else begin
                        map_x     <= clr_x;
                        map_y     <= clr_y;
                        map_wdata <= clear_tile(clr_x, clr_y);
                    end
                end
                S_PLACE1: begin
                    state          <= S_PLACE2;
                    head1          <= P1_POS;
                    heading1       <= D_RIGHT;
                    {map_y, map_x} <= P2_POS;
                    map_wdata      <= T_PLAYER2;
                end
                S_PLACE2: begin
                    state     <= S_RUN;
                    head2     <= P2_POS;
                    heading2  <= D_LEFT;
                    map_we    <= 1'b0;
                    map_wdata <= T_EMPTY;
                    mode      <= M_GAME;
                    busy      <= 1'b0;
                end
                S_RUN: begin
                    if (tick) begin
                        state          <= S_RD1;
                        heading1       <= h1_req;
                        heading2       <= h2_req;
                        {map_y, map_x} <= n1_req;
                        busy           <= 1'b1;
                    end
                end
                S_RD1: begin
                    state          <= S_RD2;
                    {map_y, map_x} <= next2;
                end
                S_RD2: begin
                    state <= S_CHK;
                    tile1 <= map_rdata;
                end
                S_CHK: begin
                    if (!crash1 && !crash2) begin
                        state          <= S_WR1;
                        {map_y, map_x} <= next1;
                        map_we         <= 1'b1;
                        map_wdata      <= T_PLAYER1;
                    end else begin
                        busy <= 1'b0;
                        if (crash1 && crash2) begin
                            state <= S_IDLE;
                            mode  <= M_START;
                        end else begin
                            state <= S_WIN;
                            mode  <= crash1 ? M_P2_WIN : M_P1_WIN;
                        end
                    end
                end
                S_WR1: begin
                    state          <= S_WR2;
                    head1          <= next1;
                    {map_y, map_x} <= next2;
                    map_wdata      <= T_PLAYER2;
                end
                S_WR2: begin
                    state     <= S_RUN;
                    head2     <= next2;
                    map_we    <= 1'b0;
                    map_wdata <= T_EMPTY;
                    busy      <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    map_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: two instances (default and P2_START_X=46) each with a behavioural tile map,
// compared against a grid-level game model plus hand-computed move vectors.
module tb_game_ctrl;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick      [N];
    logic       start_btn [N];
    logic [2:0] dir1      [N];
    logic [2:0] dir2      [N];
    logic [5:0] map_x     [N];
    logic [5:0] map_y     [N];
    logic       map_we    [N];
    logic [1:0] map_wdata [N];
    logic [1:0] map_rdata [N];
    logic [1:0] mode      [N];
    logic       busy      [N];

    always #5 clk = ~clk;

    game_ctrl u_dut0 (
        .clk(clk), .rst(rst), .tick(tick[0]), .start_btn(start_btn[0]),
        .dir1(dir1[0]), .dir2(dir2[0]), .map_x(map_x[0]), .map_y(map_y[0]),
        .map_we(map_we[0]), .map_wdata(map_wdata[0]), .map_rdata(map_rdata[0]),
        .mode(mode[0]), .busy(busy[0])
    );

    game_ctrl #(.P2_START_X(46)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick[1]), .start_btn(start_btn[1]),
        .dir1(dir1[1]), .dir2(dir2[1]), .map_x(map_x[1]), .map_y(map_y[1]),
        .map_we(map_we[1]), .map_wdata(map_wdata[1]), .map_rdata(map_rdata[1]),
        .mode(mode[1]), .busy(busy[1])
    );

    // Tile RAM with registered read; the write counter lets ticks prove "no write".
    logic [1:0] mem [N][4096];
    int         wr_cnt [N] = '{0, 0};

    always @(posedge clk) begin
        for (int u = 0; u < N; u++) begin
            if (map_we[u]) begin
                mem[u][{map_y[u], map_x[u]}] <= map_wdata[u];
                wr_cnt[u] <= wr_cnt[u] + 1;
            end else begin
                map_rdata[u] <= mem[u][{map_y[u], map_x[u]}];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int addr_of(input int u);
        return int'({map_y[u], map_x[u]});
    endfunction

    // ---------------- game model ----------------
    int m_grid [N][4096];
    int mx1 [N], my1 [N], mx2 [N], my2 [N], mh1 [N], mh2 [N];

    function automatic int dx_of(input int h);
        return (h == 1) ? 1 : (h == 2) ? -1 : 0;
    endfunction

    function automatic int dy_of(input int h);
        return (h == 4) ? 1 : (h == 3) ? -1 : 0;
    endfunction

    function automatic int opposite(input int h);
        case (h)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int p2x_of(input int u);
        return (u == 0) ? 47 : 46;
    endfunction

    task automatic model_start(input int u);
        for (int y = 0; y < 48; y++)
            for (int x = 0; x < 64; x++)
                m_grid[u][y*64+x] = (x == 0 || x == 63 || y == 0 || y == 47) ? 3 : 0;
        mx1[u] = 16; my1[u] = 24; mx2[u] = p2x_of(u); my2[u] = 24;
        m_grid[u][my1[u]*64+mx1[u]] = 1;
        m_grid[u][my2[u]*64+mx2[u]] = 2;
        mh1[u] = 1; mh2[u] = 2;
    endtask

    // res is the expected mode afterwards: 1 moved, 2 p1 wins, 3 p2 wins, 0 draw
    task automatic model_step(input int u, input int d1, input int d2,
                              output int n1x, output int n1y, output int n2x, output int n2y,
                              output int res);
        bit c1, c2, same;
        if (d1 >= 1 && d1 <= 4 && d1 != opposite(mh1[u])) mh1[u] = d1;
        if (d2 >= 1 && d2 <= 4 && d2 != opposite(mh2[u])) mh2[u] = d2;
        n1x = mx1[u] + dx_of(mh1[u]); n1y = my1[u] + dy_of(mh1[u]);
        n2x = mx2[u] + dx_of(mh2[u]); n2y = my2[u] + dy_of(mh2[u]);
        same = (n1x == n2x) && (n1y == n2y);
        c1 = (m_grid[u][n1y*64+n1x] != 0) || same;
        c2 = (m_grid[u][n2y*64+n2x] != 0) || same;
        if (!c1 && !c2) begin
            m_grid[u][n1y*64+n1x] = 1;
            m_grid[u][n2y*64+n2x] = 2;
            mx1[u] = n1x; my1[u] = n1y; mx2[u] = n2x; my2[u] = n2y;
            res = 1;
        end else if (c1 && c2) res = 0;
        else if (c1) res = 3;
        else res = 2;
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic do_start(input int u, input int stop_at);
        int errs, ex, ey, et;
        errs = 0;
        @(negedge clk); start_btn[u] = 1'b1;
        @(negedge clk); start_btn[u] = 1'b0;
        for (int i = 0; i < stop_at; i++) begin
            ex = i % 64; ey = i / 64;
            et = (ex == 0 || ex == 63 || ey == 0 || ey == 47) ? 3 : 0;
            if (i == 0) check("clear_origin", addr_of(u), 0);
            if (map_we[u] !== 1'b1 || addr_of(u) != ey*64+ex || int'(map_wdata[u]) != et
                || busy[u] !== 1'b1) errs++;
            @(negedge clk);
        end
        check("clear_sequence_errors", errs, 0);
        if (stop_at < 3072) return;
        check("place1_we", int'(map_we[u]), 1);
        check("place1_addr", addr_of(u), 24*64+16);
        check("place1_data", int'(map_wdata[u]), 1);
        @(negedge clk);
        check("place2_addr", addr_of(u), 24*64+p2x_of(u));
        check("place2_data", int'(map_wdata[u]), 2);
        @(negedge clk);
        check("run_mode", int'(mode[u]), 1);
        check("run_busy", int'(busy[u]), 0);
        check("run_we", int'(map_we[u]), 0);
        check("run_wdata", int'(map_wdata[u]), 0);
        check("map_0_0", int'(mem[u][0]), 3);
        check("map_10_10", int'(mem[u][10*64+10]), 0);
        check("map_63_47", int'(mem[u][47*64+63]), 3);
        model_start(u);
    endtask

    task automatic do_tick(input int u, input int d1, input int d2, input bit extra,
                           output int r1, output int r2, output int md);
        int n1x, n1y, n2x, n2y, res, w0, k;
        model_step(u, d1, d2, n1x, n1y, n2x, n2y, res);
        w0 = wr_cnt[u];
        @(negedge clk);
        tick[u] = 1'b1; dir1[u] = 3'(d1); dir2[u] = 3'(d2);
        @(negedge clk);
        tick[u] = 1'b0;
        r1 = addr_of(u);
        check("rd1_addr", r1, n1y*64+n1x);
        check("rd1_we", int'(map_we[u]), 0);
        check("rd1_busy", int'(busy[u]), 1);
        @(negedge clk);
        if (extra) tick[u] = 1'b1;
        r2 = addr_of(u);
        check("rd2_addr", r2, n2y*64+n2x);
        @(negedge clk);
        tick[u] = 1'b0;
        k = 3;
        while (busy[u] === 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
            if (res == 1 && k == 4) begin
                check("wr1_addr", addr_of(u), n1y*64+n1x);
                check("wr1_data", int'(map_we[u]) * 4 + int'(map_wdata[u]), 4 + 1);
            end
            if (res == 1 && k == 5) begin
                check("wr2_addr", addr_of(u), n2y*64+n2x);
                check("wr2_data", int'(map_we[u]) * 4 + int'(map_wdata[u]), 4 + 2);
            end
        end
        check("tick_latency", k, (res == 1) ? 6 : 4);
        @(negedge clk);
        check("tick_writes", wr_cnt[u] - w0, (res == 1) ? 2 : 0);
        md = int'(mode[u]);
        check("tick_mode", md, res);
    endtask

    task automatic dead_tick(input int u, input int exp_mode);
        int w0;
        w0 = wr_cnt[u];
        @(negedge clk); tick[u] = 1'b1; dir1[u] = 3'd1; dir2[u] = 3'd1;
        @(negedge clk); tick[u] = 1'b0;
        check("dead_tick_busy", int'(busy[u]), 0);
        repeat (6) @(negedge clk);
        check("dead_tick_writes", wr_cnt[u] - w0, 0);
        check("dead_tick_mode", int'(mode[u]), exp_mode);
    endtask

    task automatic compare_map(input int u);
        int errs;
        errs = 0;
        for (int i = 0; i < 3072; i++)
            if (int'(mem[u][i]) != m_grid[u][i]) errs++;
        check("map_vs_model", errs, 0);
    endtask

    typedef struct {
        int d1; int d2;
        int n1x; int n1y; int n2x; int n2y;
        int md;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, r2, md, w0, res, d1, d2;

        tbl[0] = '{0, 0, 17, 24, 46, 24, 1};
        tbl[1] = '{2, 0, 18, 24, 45, 24, 1};
        tbl[2] = '{3, 4, 18, 23, 45, 25, 1};
        tbl[3] = '{4, 3, 18, 22, 45, 26, 1};
        tbl[4] = '{1, 2, 19, 22, 44, 26, 1};
        tbl[5] = '{0, 3, 20, 22, 44, 25, 1};

        rst = 1'b1;
        for (int u = 0; u < N; u++) begin
            tick[u] = 1'b0; start_btn[u] = 1'b0; dir1[u] = 3'd0; dir2[u] = 3'd0;
        end
        #1;
        check("reset_mode", int'(mode[0]), 0);
        check("reset_busy", int'(busy[0]), 0);
        check("reset_we", int'(map_we[0]), 0);
        check("reset_addr", addr_of(0), 0);
        check("reset_wdata", int'(map_wdata[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_hold_busy", int'(busy[0]), 0);
        check("idle_hold_we", int'(map_we[0]), 0);

        // start, start_btn ignored while running, then the move table
        do_start(0, 3072);
        w0 = wr_cnt[0];
        @(negedge clk); start_btn[0] = 1'b1;
        @(negedge clk); start_btn[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("start_in_run_busy", int'(busy[0]), 0);
        check("start_in_run_mode", int'(mode[0]), 1);
        check("start_in_run_writes", wr_cnt[0] - w0, 0);

        for (int i = 0; i < 6; i++) begin
            do_tick(0, tbl[i].d1, tbl[i].d2, 1'b0, r1, r2, md);
            check("tbl_rd1", r1, tbl[i].n1y*64 + tbl[i].n1x);
            check("tbl_rd2", r2, tbl[i].n2y*64 + tbl[i].n2x);
            check("tbl_mode", md, tbl[i].md);
        end

        // second tick during busy must be dropped
        do_tick(0, 0, 0, 1'b1, r1, r2, md);
        check("drop_first_rd1", r1, 22*64+21);
        do_tick(0, 0, 0, 1'b0, r1, r2, md);
        check("drop_next_rd1", r1, 22*64+22);
        check("drop_next_rd2", r2, 23*64+44);
        compare_map(0);

        // player 1 drives up into the frame
        pulse_rst();
        do_start(0, 3072);
        for (int t = 1; t <= 24; t++) begin
            do_tick(0, 3, 0, 1'b0, r1, r2, md);
            if (t == 24) begin
                check("frame_crash_rd1", r1, 0*64+16);
                check("frame_crash_mode", md, 3);
            end
        end
        dead_tick(0, 3);

        // head-on draw on the shifted instance
        do_start(1, 3072);
        for (int t = 1; t <= 15; t++) begin
            do_tick(1, 0, 0, 1'b0, r1, r2, md);
            if (t == 15) begin
                check("draw_same_rd1", r1, 24*64+31);
                check("draw_same_rd2", r2, 24*64+31);
                check("draw_same_mode", md, 0);
                check("draw_same_busy", int'(busy[1]), 0);
            end
        end
        dead_tick(1, 0);

        // default instance: heads swap into each other's tiles
        do_start(0, 3072);
        for (int t = 1; t <= 16; t++) begin
            do_tick(0, 0, 0, 1'b0, r1, r2, md);
            if (t == 16) check("draw_cross_mode", md, 0);
        end
        compare_map(0);

        // reset in the middle of CLEAR
        do_start(0, 1000);
        rst = 1'b1;
        #1;
        check("midclear_rst_we", int'(map_we[0]), 0);
        check("midclear_rst_mode", int'(mode[0]), 0);
        check("midclear_rst_busy", int'(busy[0]), 0);
        check("midclear_rst_addr", addr_of(0), 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midclear_idle_busy", int'(busy[0]), 0);
        do_start(0, 3072);

        // random games against the model
        for (int g = 0; g < 4; g++) begin
            pulse_rst();
            do_start(0, 3072);
            res = 1;
            for (int t = 0; t < 150 && res == 1; t++) begin
                d1 = int'($urandom_range(0, 4));
                d2 = int'($urandom_range(0, 4));
                do_tick(0, d1, d2, ($urandom_range(0, 7) == 0), r1, r2, res);
            end
            compare_map(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
